// File: rtl/hilo_div_unit_pkg.sv
// Shared types and constants for the HI/LO register pair and its iterative divider.
package hilo_div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_CALC = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    // Iteration counter width; wide enough to hold DIV_CYCLES-1 for a 32-bit datapath.
    localparam int CNT_W = 6;

    localparam logic HILO_SEL_HI = 1'b1;
    localparam logic HILO_SEL_LO = 1'b0;

    // Quotient reported for a zero divisor, sliced down to the datapath width.
    localparam logic [63:0] DIV_ZERO_LO = '1;

    typedef struct packed {
        logic q_neg;
        logic r_neg;
        logic b_zero;
    } div_flags_t;

endpackage

// File: rtl/hilo_div_unit_if.sv
// Pipeline-facing signal bundle of the HI/LO/divide unit: M-stage moves, E-stage divide, stall/ready, HI/LO read.
interface hilo_div_unit_if #(
    parameter int WIDTH = 32
) ();

    logic             hilowriteM;
    logic             hilo_selM;
    logic [WIDTH-1:0] hilo_wdataM;
    logic             div_startE;
    logic             div_signedE;
    logic [WIDTH-1:0] div_aE;
    logic [WIDTH-1:0] div_bE;
    logic             div_cancel;
    logic             div_stallE;
    logic             div_readyE;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output hilowriteM, hilo_selM, hilo_wdataM,
        output div_startE, div_signedE, div_aE, div_bE, div_cancel,
        input  div_stallE, div_readyE, hi_o, lo_o
    );

    modport slave (
        input  hilowriteM, hilo_selM, hilo_wdataM,
        input  div_startE, div_signedE, div_aE, div_bE, div_cancel,
        output div_stallE, div_readyE, hi_o, lo_o
    );

endinterface

// File: rtl/hilo_div_unit_div_core.sv
// Unsigned restoring shift-subtract divider, one quotient bit per cycle for DIV_CYCLES cycles.
module hilo_div_unit_div_core
    import hilo_div_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic             busy_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dvs_reg;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             fits;

    // Partial remainder gains the next dividend bit; an extra top bit keeps the trial subtract exact.
    assign shifted = {rem_reg, quo_reg[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_reg};
    assign fits    = ~diff[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_reg <= 1'b0;
            cnt_reg  <= '0;
            quo_reg  <= '0;
            rem_reg  <= '0;
            dvs_reg  <= '0;
        end else if (cancel) begin
            busy_reg <= 1'b0;
        end else if (start) begin
            busy_reg <= 1'b1;
            cnt_reg  <= CNT_W'(DIV_CYCLES - 1);
            quo_reg  <= dividend;
            rem_reg  <= '0;
            dvs_reg  <= divisor;
        end else if (busy_reg) begin
            rem_reg <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            quo_reg <= {quo_reg[WIDTH-2:0], fits};
            cnt_reg <= cnt_reg - 1'b1;
            if (cnt_reg == '0) begin
                busy_reg <= 1'b0;
            end
        end
    end

    // Asserted during the final iteration; results are settled on the following cycle.
    assign done      = busy_reg && (cnt_reg == '0);
    assign quotient  = quo_reg;
    assign remainder = rem_reg;

endmodule

// File: rtl/hilo_div_unit.sv
// HI/LO register pair with a multi-cycle DIV/DIVU engine, stall/ready handshake and MTHI/MTLO writes.
// Optional build macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase.
module hilo_div_unit
    import hilo_div_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic           clk,
    input  logic           rst,
    hilo_div_unit_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    div_state_e       state_reg;
    logic             ready_reg;
    div_flags_t       flags_reg;
    logic [WIDTH-1:0] a_raw_reg;

    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic             fast_zero;
    logic             start_accept;
    logic             core_start;
    logic             core_done;
    logic             commit;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] core_quo;
    logic [WIDTH-1:0] core_rem;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] div_res [2];

    // Signed operands are divided as magnitudes; the most negative value maps onto itself, which is the right magnitude.
    assign a_neg  = bus.div_signedE & bus.div_aE[WIDTH-1];
    assign b_neg  = bus.div_signedE & bus.div_bE[WIDTH-1];
    assign a_mag  = a_neg ? (~bus.div_aE + ONE) : bus.div_aE;
    assign b_mag  = b_neg ? (~bus.div_bE + ONE) : bus.div_bE;
    assign b_zero = (bus.div_bE == '0);

`ifdef DIV_ZERO_FAST_EN
    assign fast_zero = b_zero;
`else
    assign fast_zero = 1'b0;
`endif

    assign start_accept = (state_reg == DIV_IDLE) & bus.div_startE & ~bus.div_cancel;
    assign core_start   = start_accept & ~fast_zero;
    assign commit       = ready_reg & ~bus.div_cancel;

    assign bus.div_stallE = ~rst & ((state_reg == DIV_CALC) | start_accept);
    assign bus.div_readyE = commit;

    hilo_div_unit_div_core #(
        .WIDTH      (WIDTH),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .start     (core_start),
        .cancel    (bus.div_cancel),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .done      (core_done),
        .quotient  (core_quo),
        .remainder (core_rem)
    );

    // A start seen in DONE belongs to the instruction being retired, so only IDLE accepts one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= DIV_IDLE;
            ready_reg <= 1'b0;
            flags_reg <= '0;
            a_raw_reg <= '0;
        end else if (bus.div_cancel) begin
            state_reg <= DIV_IDLE;
            ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                DIV_IDLE: begin
                    if (bus.div_startE) begin
                        flags_reg.q_neg  <= a_neg ^ b_neg;
                        flags_reg.r_neg  <= a_neg;
                        flags_reg.b_zero <= b_zero;
                        a_raw_reg        <= bus.div_aE;
                        if (fast_zero) begin
                            state_reg <= DIV_DONE;
                            ready_reg <= 1'b1;
                        end else begin
                            state_reg <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    if (core_done) begin
                        state_reg <= DIV_DONE;
                        ready_reg <= 1'b1;
                    end
                end
                DIV_DONE: begin
                    state_reg <= DIV_IDLE;
                    ready_reg <= 1'b0;
                end
                default: begin
                    state_reg <= DIV_IDLE;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    // Zero divisor reports all-ones quotient and the untouched dividend, regardless of signedness.
    assign q_fix = flags_reg.b_zero ? DIV_ZERO_LO[WIDTH-1:0]
                 : (flags_reg.q_neg ? (~core_quo + ONE) : core_quo);
    assign r_fix = flags_reg.b_zero ? a_raw_reg
                 : (flags_reg.r_neg ? (~core_rem + ONE) : core_rem);

    assign div_res[0] = q_fix;
    assign div_res[1] = r_fix;

    // Index 0 is LO, index 1 is HI; a committing divide is younger than the M-stage move, so it wins.
    for (genvar gi = 0; gi < 2; gi++) begin : g_hilo
        localparam logic SEL = (gi == 1) ? HILO_SEL_HI : HILO_SEL_LO;
        logic [WIDTH-1:0] val_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                val_reg <= '0;
            end else if (commit) begin
                val_reg <= div_res[gi];
            end else if (bus.hilowriteM && (bus.hilo_selM == SEL)) begin
                val_reg <= bus.hilo_wdataM;
            end
        end
    end

    assign bus.lo_o = g_hilo[0].val_reg;
    assign bus.hi_o = g_hilo[1].val_reg;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: cycle-level model plus directed divide/move/cancel/reset vectors.
module tb_hilo_div_unit;

`ifdef DIV_ZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;
    bit   chk_en;

    hilo_div_unit_if #(.WIDTH(32)) bus ();

    hilo_div_unit #(
        .WIDTH      (32),
        .DIV_CYCLES (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp_v, $time);
        end
    endfunction

    // Architectural result of DIV/DIVU: {HI, LO}
    function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint sa, sb, q, r;
        logic [31:0] lo, hi;
        if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            lo = q[31:0];
            hi = r[31:0];
        end else begin
            lo = a / b;
            hi = a % b;
        end
        return {hi, lo};
    endfunction

    // Model: m_left counts cycles remaining until the ready cycle (1 = ready cycle, 0 = no divide)
    int          m_left;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_res  <= '0;
        end else begin
            if (bus.hilowriteM) begin
                if (bus.hilo_selM) m_hi <= bus.hilo_wdataM;
                else               m_lo <= bus.hilo_wdataM;
            end
            if (bus.div_cancel) begin
                m_left <= 0;
            end else if (m_left == 1) begin
                m_hi   <= m_res[63:32];
                m_lo   <= m_res[31:0];
                m_left <= 0;
            end else if (m_left > 1) begin
                m_left <= m_left - 1;
            end else if (bus.div_startE) begin
                m_res  <= model_div(bus.div_aE, bus.div_bE, bus.div_signedE);
                m_left <= (FAST && bus.div_bE == 32'd0) ? 1 : 33;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("cyc_stall", 32'(bus.div_stallE),
                  32'((m_left > 1) || (m_left == 0 && bus.div_startE && !bus.div_cancel)));
            check("cyc_ready", 32'(bus.div_readyE), 32'((m_left == 1) && !bus.div_cancel));
            check("cyc_hi", bus.hi_o, m_hi);
            check("cyc_lo", bus.lo_o, m_lo);
        end
    end

    // Called just after a rising edge; returns just after the edge that ends DONE.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                          input logic [31:0] elo, input logic [31:0] ehi,
                          input int mt_cyc, input bit mt_sel, input logic [31:0] mt_data);
        int cyc;
        int exp_lat;
        bit got;
        exp_lat = (FAST && b == 32'd0) ? 2 : 34;
        bus.div_startE  = 1'b1;
        bus.div_aE      = a;
        bus.div_bE      = b;
        bus.div_signedE = s;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc <= 100) begin
            bus.hilowriteM  = (cyc == mt_cyc);
            bus.hilo_selM   = mt_sel;
            bus.hilo_wdataM = mt_data;
            @(negedge clk);
            if (mt_cyc > 0 && cyc == mt_cyc + 1 && cyc <= exp_lat)
                check("mt_interim", mt_sel ? bus.hi_o : bus.lo_o, mt_data);
            if (bus.div_readyE) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ready_timeout actual=none required=ready a=%h b=%h", a, b);
        end
        check("latency", 32'(cyc), 32'(exp_lat));
        @(posedge clk);
        #1;
        bus.div_startE = 1'b0;
        bus.hilowriteM = 1'b0;
        check("div_lo", bus.lo_o, elo);
        check("div_hi", bus.hi_o, ehi);
        $display("div a=%h b=%h signed=%0d -> lo=%h hi=%h latency=%0d", a, b, s, bus.lo_o, bus.hi_o, cyc);
    endtask

    logic [31:0] va  [9] = '{32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB,
                             32'd7, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FF9C};
    logic [31:0] vb  [9] = '{32'd7, 32'd2, 32'hFFFF_FFFF, 32'd0, 32'd0,
                             32'hFFFF_FFFE, 32'd1, 32'd10, 32'hFFFF_FFF9};
    bit          vs  [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] vlo [9] = '{32'd14, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd0, 32'd14};
    logic [31:0] vhi [9] = '{32'd2, 32'hFFFF_FFFF, 32'd0, 32'd5, 32'hFFFF_FFFB,
                             32'd1, 32'd0, 32'd3, 32'hFFFF_FFFE};

    initial begin
        int readies;
        total  = 0;
        bad    = 0;
        chk_en = 1'b0;
        rst    = 1'b1;
        bus.hilowriteM  = 1'b0;
        bus.hilo_selM   = 1'b0;
        bus.hilo_wdataM = '0;
        bus.div_startE  = 1'b0;
        bus.div_signedE = 1'b0;
        bus.div_aE      = '0;
        bus.div_bE      = '0;
        bus.div_cancel  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_hi", bus.hi_o, 32'd0);
        check("rst_lo", bus.lo_o, 32'd0);
        check("rst_stall", 32'(bus.div_stallE), 32'd0);
        check("rst_ready", 32'(bus.div_readyE), 32'd0);
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // Idle MTHI / MTLO
        bus.hilowriteM = 1'b1; bus.hilo_selM = 1'b1; bus.hilo_wdataM = 32'h0000_BEEF;
        @(posedge clk); #1;
        bus.hilo_selM = 1'b0; bus.hilo_wdataM = 32'h0000_5A5A;
        @(posedge clk); #1;
        bus.hilowriteM = 1'b0;
        @(negedge clk);
        check("mthi_idle", bus.hi_o, 32'h0000_BEEF);
        check("mtlo_idle", bus.lo_o, 32'h0000_5A5A);
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++)
            do_div(va[i], vb[i], vs[i], vlo[i], vhi[i], 0, 1'b0, '0);

        // MTHI during CALC cycle 10, divide result overwrites it afterwards
        do_div(32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 11, 1'b1, 32'h0000_1234);
        // MTLO on the same edge as the commit: divide wins
        do_div(32'd200, 32'd9, 1'b0, 32'd22, 32'd2, 34, 1'b0, 32'h0000_AAAA);

        // Cancel in CALC cycle 5
        bus.div_startE = 1'b1; bus.div_aE = 32'd50; bus.div_bE = 32'd3; bus.div_signedE = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        bus.div_cancel = 1'b1;
        @(negedge clk);
        check("cancel_stall_during", 32'(bus.div_stallE), 32'd1);
        check("cancel_ready_during", 32'(bus.div_readyE), 32'd0);
        @(posedge clk); #1;
        bus.div_cancel = 1'b0;
        bus.div_startE = 1'b0;
        @(negedge clk);
        check("cancel_stall_after", 32'(bus.div_stallE), 32'd0);
        check("cancel_lo_kept", bus.lo_o, 32'd22);
        check("cancel_hi_kept", bus.hi_o, 32'd2);
        @(posedge clk); #1;
        do_div(32'd1003, 32'd10, 1'b0, 32'd100, 32'd3, 0, 1'b0, '0);

        // Asynchronous reset mid-CALC
        bus.div_startE = 1'b1; bus.div_aE = 32'd77; bus.div_bE = 32'd5; bus.div_signedE = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        #2;
        rst = 1'b1;
        #1;
        check("arst_stall", 32'(bus.div_stallE), 32'd0);
        check("arst_ready", 32'(bus.div_readyE), 32'd0);
        check("arst_hi", bus.hi_o, 32'd0);
        check("arst_lo", bus.lo_o, 32'd0);
        bus.div_startE = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        readies = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.div_readyE) readies++;
        end
        check("arst_no_ready", 32'(readies), 32'd0);
        check("arst_hi_final", bus.hi_o, 32'd0);
        check("arst_lo_final", bus.lo_o, 32'd0);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Owns the architectural HI/LO register pair.
- Contains a multi-cycle radix-2 divider for DIV/DIVU.
- Consumes the M-stage hilowrite control from the main decoder for MTHI/MTLO, and a divide request from the E stage.
- Drives a stall to the hazard unit while a divide is in flight, and provides HI/LO read data to the E-stage operand mux.

Parameters:
- WIDTH, 32, data width of HI, LO and the divide operands.
- DIV_CYCLES, 32, iteration count of the CALC state; must equal WIDTH.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- hilowriteM  in  1  MTHI/MTLO commit in the M stage.
- hilo_selM  in  1  target of hilowriteM: 1 = HI, 0 = LO.
- hilo_wdataM  in  WIDTH  value written by MTHI/MTLO.
- div_startE  in  1  DIV/DIVU present in the E stage.
- div_signedE  in  1  1 = DIV, 0 = DIVU.
- div_aE  in  WIDTH  dividend (rs).
- div_bE  in  WIDTH  divisor (rt).
- div_cancel  in  1  E-stage flush; abort any divide.
- div_stallE  out  1  hold F/D/E stages.
- div_readyE  out  1  one-cycle pulse; result committed this cycle.
- hi_o  out  WIDTH  current HI.
- lo_o  out  WIDTH  current LO.

Behaviour:
- Reset (async, any state): HI = 0, LO = 0, state = IDLE, div_readyE = 0, div_stallE = 0. All divider working registers are cleared.
- States: IDLE, CALC, DONE.
- IDLE:
  - div_startE = 1 and div_cancel = 0: latch operands and go to CALC.
  - Signed mode latches magnitudes plus two sign flags: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - div_stallE = div_startE AND NOT div_cancel, combinationally, in this cycle.
- CALC:
  - Runs exactly DIV_CYCLES cycles of shift-subtract using a 6-bit iteration counter that counts down to 0.
  - Then go to DONE. div_stallE = 1 throughout.
- DONE:
  - div_stallE = 0 and div_readyE = 1.
  - At the clock edge ending DONE: LO = quotient, HI = remainder, with signs applied as two's-complement negation. Then go to IDLE.
  - div_startE is ignored in DONE, because the same instruction is still in E.
- Total latency: start cycle + 32 CALC + 1 DONE = 34 cycles from E entry to E exit. HI/LO are visible on hi_o/lo_o from cycle 35.
- div_cancel in any state: next state = IDLE, no HI/LO update, div_readyE = 0 in that cycle.
- Division by zero: LO = all ones, HI = div_aE raw, for both signed and unsigned. No exception.
- Signed overflow (0x80000000 / -1): LO = 0x80000000, HI = 0.
- hilowriteM:
  - Writes the selected register at the clock edge; accepted in every state.
  - Same edge as a DONE commit: the divide result wins on both HI and LO (the divide is the younger instruction).
- hi_o/lo_o are direct register outputs; there is no write-through bypass.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined: a zero divisor detected in IDLE goes straight to DONE, so latency is 2 cycles (start, DONE). Results are as specified above.
- Undefined: a zero divisor runs the full 32 CALC cycles and produces the identical result.
- Stall and ready semantics are unchanged in both builds.

Decomposition:
- defines.vh holds:
  - state encodings DIV_IDLE, DIV_CALC, DIV_DONE (2-bit);
  - DIV_ZERO_LO constant (all ones);
  - HILO_SEL_HI / HILO_SEL_LO encodings.
- Natural sub-module: div_core. It holds the iterative shift-subtract datapath and counter, with start/cancel in and done/quotient/remainder out. hilo_div_unit keeps the FSM, sign fix-up, write arbitration and the HI/LO registers.

Test Plan:
- DIVU 100 / 7: stall for 33 cycles from start, ready pulse at cycle 34 → LO = 14, HI = 2.
- DIV -7 / 2 → LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1). DIV 0x80000000 / -1 → LO = 0x80000000, HI = 0.
- DIVU 5 / 0 → LO = 0xFFFFFFFF, HI = 5. Latency is 34 cycles without DIV_ZERO_FAST_EN and 2 cycles with it.
- MTHI 0x1234 during cycle 10 of CALC, then divide 9 / 4 completes → HI ends at 1 (divide overwrites). hi_o reads 0x1234 in the interim.
- div_cancel asserted in CALC cycle 5 → state IDLE next cycle, stall drops, HI/LO unchanged. A new divide started next cycle gives a correct result.
- rst pulsed mid-CALC → HI = LO = 0, stall = 0 immediately (async). No ready pulse afterwards.
